// File: rtl/vga_demo_pkg.sv
// ============================================================================
// Module      : vga_demo_pkg
// Description : Shared state encodings and LFSR constants for the VGA demo
//               sequencer family.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_demo_pkg;

  localparam int unsigned SEQ_STATE_W = 3;

  localparam logic [SEQ_STATE_W-1:0] S_TP     = 3'd0;
  localparam logic [SEQ_STATE_W-1:0] S_DEMO_A = 3'd1;
  localparam logic [SEQ_STATE_W-1:0] S_GAP_A  = 3'd2;
  localparam logic [SEQ_STATE_W-1:0] S_DEMO_B = 3'd3;
  localparam logic [SEQ_STATE_W-1:0] S_GAP_B  = 3'd4;

  // Galois taps for x^32 + x^22 + x^2 + x + 1, right-shifting form
  localparam logic [31:0] LFSR_MASK         = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED_DEFAULT = 32'hACE1_2468;

endpackage

`default_nettype wire

// File: rtl/vga_lfsr32.sv
// ============================================================================
// Module      : vga_lfsr32
// Description : 32-bit Galois LFSR stepping every clock, with a zero-lock
//               guard that reloads the seed if the all-zero state appears.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_lfsr32
  import vga_demo_pkg::*;
(
  input  logic        clk_dot,
  input  logic        reset_n,
  input  logic [31:0] seed,
  output logic [31:0] q
);

  logic [31:0] r_q;
  logic [31:0] w_q_next;

  always_comb begin
    w_q_next = {1'b0, r_q[31:1]} ^ (r_q[0] ? LFSR_MASK : 32'h0);
    if (r_q == 32'h0) begin
      w_q_next = seed;
    end
  end

  always_ff @(posedge clk_dot) begin
    if (!reset_n) begin
      r_q <= seed;
    end else begin
      r_q <= w_q_next;
    end
  end

  assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/vga_demo_seq.sv
// ============================================================================
// Module      : vga_demo_seq
// Description : Frame-synchronous sequencer: test pattern -> demo A -> gap ->
//               demo B -> gap, driving mode/colour-depth/seed of the pixel
//               core. Optional macro VGA_DEMO_SEQ_COLOR_CYCLE_EN makes
//               color_3b toggle on every GAP_B -> TP wrap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_demo_seq
  import vga_demo_pkg::*;
#(
  parameter int unsigned DWELL_FRAMES = 600,
  parameter int unsigned GAP_FRAMES   = 1,
  parameter logic [31:0] LFSR_SEED    = LFSR_SEED_DEFAULT
) (
  input  logic                   clk_dot,
  input  logic                   reset_n,
  input  logic                   vid_new_frame,
  input  logic                   auto_en,
  input  logic                   next_req,
  input  logic                   color_3b_req,
  output logic                   mode_bit,
  output logic                   color_3b,
  output logic [31:0]            random_num,
  output logic [SEQ_STATE_W-1:0] seq_state,
  output logic                   demo_b_sel
);

  // Zero-length dwell/gap parameters behave as one frame
  localparam logic [15:0] c_dwell_last = (DWELL_FRAMES == 0) ? 16'd0 : 16'(DWELL_FRAMES - 1);
  localparam logic [15:0] c_gap_last   = (GAP_FRAMES == 0)   ? 16'd0 : 16'(GAP_FRAMES - 1);

  logic [SEQ_STATE_W-1:0] r_state;
  logic [SEQ_STATE_W-1:0] w_state_next;
  logic [15:0]            r_dwell_cnt;
  logic [15:0]            w_cnt_next;
  logic                   r_next_pend;
  logic                   w_pend_next;
  logic                   r_mode_bit;
  logic                   w_mode_next;
  logic                   r_color_3b;
  logic                   w_color_next;
  logic                   w_is_dwell;
  logic                   w_advance;

  // State register and frame counters
  always_ff @(posedge clk_dot) begin
    if (!reset_n) begin
      r_state     <= S_TP;
      r_dwell_cnt <= 16'd0;
      r_next_pend <= 1'b0;
      r_mode_bit  <= 1'b0;
      r_color_3b  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_dwell_cnt <= w_cnt_next;
      r_next_pend <= w_pend_next;
      r_mode_bit  <= w_mode_next;
      r_color_3b  <= w_color_next;
    end
  end

  // Next-state logic; nothing moves except on a frame pulse
  always_comb begin
    w_is_dwell = (r_state == S_TP) || (r_state == S_DEMO_A) || (r_state == S_DEMO_B);
    w_advance  = 1'b0;
    if (vid_new_frame) begin
      if (w_is_dwell) begin
        w_advance = (auto_en && (r_dwell_cnt == c_dwell_last)) || r_next_pend || next_req;
      end else begin
        w_advance = (r_dwell_cnt == c_gap_last);
      end
    end

    w_state_next = r_state;
    if (w_advance) begin
      case (r_state)
        S_TP:     w_state_next = S_DEMO_A;
        S_DEMO_A: w_state_next = S_GAP_A;
        S_GAP_A:  w_state_next = S_DEMO_B;
        S_DEMO_B: w_state_next = S_GAP_B;
        default:  w_state_next = S_TP;
      endcase
    end

    w_cnt_next = r_dwell_cnt;
    if (w_advance) begin
      w_cnt_next = 16'd0;
    end else if (vid_new_frame && (r_dwell_cnt != 16'hFFFF)) begin
      w_cnt_next = r_dwell_cnt + 16'd1;
    end

    // A gap's advance also swallows any request made during the gap
    w_pend_next = w_advance ? 1'b0 : (r_next_pend | next_req);
  end

  // Output logic; mode_bit lags the state by one registered clock
  always_comb begin
    w_mode_next = (r_state == S_DEMO_A) || (r_state == S_DEMO_B);
`ifdef VGA_DEMO_SEQ_COLOR_CYCLE_EN
    w_color_next = (w_advance && (r_state == S_GAP_B)) ? ~r_color_3b : r_color_3b;
`else
    w_color_next = vid_new_frame ? color_3b_req : r_color_3b;
`endif
  end

`ifdef VGA_DEMO_SEQ_COLOR_CYCLE_EN
  logic w_unused_color_req;
  assign w_unused_color_req = color_3b_req;
`endif

  vga_lfsr32 u_lfsr (
    .clk_dot (clk_dot),
    .reset_n (reset_n),
    .seed    (LFSR_SEED),
    .q       (random_num)
  );

  assign mode_bit   = r_mode_bit;
  assign color_3b   = r_color_3b;
  assign seq_state  = r_state;
  assign demo_b_sel = (r_state == S_DEMO_B);

endmodule

`default_nettype wire

// File: tb/tb_vga_demo_seq.sv
// ============================================================================
// Module      : tb_vga_demo_seq
// Description : Scoreboard bench for vga_demo_seq with a frame-level model
//               of the sequence and a polynomial model of the LFSR.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_vga_demo_seq;

  localparam int          DW   = 3;
  localparam int          GP   = 1;
  localparam logic [31:0] SEED = 32'hACE1_2468;

  logic        clk_dot = 1'b0;
  logic        reset_n = 1'b0;
  logic        vid_new_frame = 1'b0;
  logic        auto_en = 1'b0;
  logic        next_req = 1'b0;
  logic        color_3b_req = 1'b0;
  logic        mode_bit;
  logic        color_3b;
  logic [31:0] random_num;
  logic [2:0]  seq_state;
  logic        demo_b_sel;

  logic        lf_rst_n = 1'b0;
  logic [31:0] lf_seed = SEED;
  logic [31:0] lf_q;

  always #5 clk_dot = ~clk_dot;

  vga_demo_seq #(.DWELL_FRAMES(DW), .GAP_FRAMES(GP), .LFSR_SEED(SEED)) dut (
    .clk_dot       (clk_dot),
    .reset_n       (reset_n),
    .vid_new_frame (vid_new_frame),
    .auto_en       (auto_en),
    .next_req      (next_req),
    .color_3b_req  (color_3b_req),
    .mode_bit      (mode_bit),
    .color_3b      (color_3b),
    .random_num    (random_num),
    .seq_state     (seq_state),
    .demo_b_sel    (demo_b_sel)
  );

  vga_lfsr32 u_lf_guard (
    .clk_dot (clk_dot),
    .reset_n (lf_rst_n),
    .seed    (lf_seed),
    .q       (lf_q)
  );

  typedef struct packed {
    logic [2:0] st;
    logic       mode;
    logic       color;
    logic       is_rst;
  } exp_t;

  exp_t q_exp[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Frame-level model: position in the five-step loop and frame count there
  int   m_idx  = 0;
  int   m_cnt  = 0;
  bit   m_pend = 1'b0;
  bit   m_color = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
  endtask

  // One step = multiply by x modulo x^32+x^22+x^2+x+1 in bit-reversed order
  function automatic logic [31:0] ref_step(input logic [31:0] s);
    logic [31:0] r;
    logic        out;
    if (s == 32'h0) return SEED;
    out = s[0];
    r   = s >> 1;
    r[31] ^= out;  // x^32 term
    r[21] ^= out;  // x^22 term
    r[1]  ^= out;  // x^2 term
    r[0]  ^= out;  // x^1 term
    return r;
  endfunction

  // Posedge sampler: which event the DUT saw, and the LFSR reference
  logic        ev_rst = 1'b0;
  logic        ev_frame = 1'b0;
  logic [31:0] m_lfsr;
  always @(posedge clk_dot) begin
    ev_rst   <= !reset_n;
    ev_frame <= reset_n && vid_new_frame;
    m_lfsr   <= !reset_n ? SEED : ref_step(m_lfsr);
  end

  // Monitor: pops one expectation per sampled event, compares every cycle
  initial begin
    exp_t       e;
    logic [2:0] cur_st;
    logic       cur_mode, cur_color, have_exp, pm_valid, pm;
    have_exp = 1'b0;
    pm_valid = 1'b0;
    pm = 1'b0;
    cur_st = 3'd0; cur_mode = 1'b0; cur_color = 1'b0;
    forever begin
      @(negedge clk_dot);
      if (pm_valid) begin
        cur_mode = pm;
        pm_valid = 1'b0;
      end
      if (ev_rst || ev_frame) begin
        if (q_exp.size() == 0) begin
          chk("queue_underflow", 64'd1, 64'd0);
        end else begin
          e = q_exp.pop_front();
          chk("event_kind", {63'd0, ev_rst}, {63'd0, e.is_rst});
          cur_st    = e.st;
          cur_color = e.color;
          have_exp  = 1'b1;
          if (e.is_rst) cur_mode = 1'b0;
          else begin
            pm_valid = 1'b1;
            pm = e.mode;
          end
        end
      end
      if (have_exp) begin
        chk("st_mode_color_bsel", {58'd0, seq_state, mode_bit, color_3b, demo_b_sel},
            {58'd0, cur_st, cur_mode, cur_color, (cur_st == 3'd3)});
        chk("random_num", {32'd0, random_num}, {32'd0, m_lfsr});
      end
    end
  end

  task automatic push_exp(input bit is_rst);
    exp_t e;
    e.st     = 3'(m_idx);
    e.mode   = (m_idx == 1) || (m_idx == 3);
    e.color  = m_color;
    e.is_rst = is_rst;
    q_exp.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_dot);
      color_3b_req = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic do_reset();
    @(negedge clk_dot);
    reset_n = 1'b0;
    m_idx = 0; m_cnt = 0; m_pend = 1'b0; m_color = 1'b0;
    push_exp(1'b1);
    @(negedge clk_dot);
    reset_n = 1'b1;
  endtask

  task automatic pulse_next();
    @(negedge clk_dot);
    next_req = 1'b1;
    m_pend = 1'b1;
    @(negedge clk_dot);
    next_req = 1'b0;
  endtask

  task automatic frame(input bit with_req);
    bit dwell, adv;
    int lim;
    @(negedge clk_dot);
    vid_new_frame = 1'b1;
    next_req = with_req;
    dwell = (m_idx == 0) || (m_idx == 1) || (m_idx == 3);
    lim   = dwell ? DW : GP;
    adv   = dwell ? ((auto_en && m_cnt == lim - 1) || m_pend || with_req) : (m_cnt == lim - 1);
`ifdef VGA_DEMO_SEQ_COLOR_CYCLE_EN
    if (adv && m_idx == 4) m_color = !m_color;
`else
    m_color = color_3b_req;
`endif
    if (adv) begin
      m_idx = (m_idx + 1) % 5;
      m_cnt = 0;
      m_pend = 1'b0;
    end else begin
      if (m_cnt < 65535) m_cnt++;
      m_pend = m_pend | with_req;
    end
    push_exp(1'b0);
    @(negedge clk_dot);
    vid_new_frame = 1'b0;
    next_req = 1'b0;
    idle(2);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    push_exp(1'b1);
    @(negedge clk_dot);
    reset_n = 1'b1;
    idle(3);

    // Auto-advance through the full loop several times
    auto_en = 1'b1;
    repeat (20) frame(1'b0);

    // Manual mode: two requests inside one frame give one advance
    do_reset();
    auto_en = 1'b0;
    frame(1'b0);
    frame(1'b0);
    idle(1);
    pulse_next();
    idle(1);
    pulse_next();
    frame(1'b0);
    frame(1'b0);

    // Request coincident with the frame, then a request inside the gap
    frame(1'b1);
    pulse_next();
    frame(1'b0);
    frame(1'b0);
    frame(1'b0);

    // Reset mid-frame while in demo B
    idle(2);
    do_reset();
    idle(3);

    // Randomised phase
    for (int i = 0; i < 250; i++) begin
      case ($urandom_range(0, 5))
        0:       auto_en = 1'($urandom_range(0, 1));
        1:       pulse_next();
        2:       frame(1'($urandom_range(0, 1)));
        3:       idle(int'($urandom_range(1, 3)));
        default: frame(1'b0);
      endcase
      if ($urandom_range(0, 99) == 0) do_reset();
    end
    idle(4);
    chk("queue_drained", 64'(q_exp.size()), 64'd0);

    // Zero-lock guard on a standalone LFSR: load zero, then expect the seed
    @(negedge clk_dot);
    lf_seed  = 32'h0;
    lf_rst_n = 1'b0;
    @(negedge clk_dot);
    lf_rst_n = 1'b1;
    lf_seed  = SEED;
    chk("lfsr_zero_loaded", {32'd0, lf_q}, 64'd0);
    @(negedge clk_dot);
    chk("lfsr_zero_reload", {32'd0, lf_q}, {32'd0, SEED});
    @(negedge clk_dot);
    chk("lfsr_after_reload", {32'd0, lf_q}, {32'd0, ref_step(SEED)});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
